lcd_avalon_slave: RTL and testbench
===================================

LCD_AVALON_SLAVE -- requirements
Module: lcd_avalon_slave

Interface
REQ-001 Parameter TAS_CYC, 3, clocks LCD_RS/LCD_DATA stable before LCD_EN rises.
REQ-002 Parameter EN_CYC, 16, clocks LCD_EN held high.
REQ-003 Parameter TH_CYC, 2, clocks LCD_RS/LCD_DATA held after LCD_EN falls.
REQ-004 Parameter EXEC_CYC, 2500, post-pulse execution wait for normal commands/data.
REQ-005 Parameter CLEAR_CYC, 82000, post-pulse execution wait for clear (0x01) and home (0x02).
REQ-006 Ports, in order:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  1  0=instruction, 1=data (becomes LCD_RS).
- chipselect  in  1  slave select.
- byteenable  in  1  byte lane enable.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  8  byte to LCD.
- readdata  out  8  read result.
- waitrequest  out  1  high = transaction not complete.
- response  out  2  00 OKAY, 10 SLVERR; valid while waitrequest low.
- LCD_DATA  out  8  HD44780 data bus.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  always 0.
- LCD_EN  out  1  enable strobe.
- LCD_ON  out  1  constant 1.
- LCD_BLON  out  1  constant 1.

Function
REQ-007 FSM states: INIT, IDLE, SETUP, PULSE, HOLD, EXEC, DONE; a single down-counter of at least 20 bits times all states.
REQ-008 IDLE with chipselect&write&~read&byteenable: latch address→LCD_RS and writedata→LCD_DATA at edge T0, then enter SETUP.
REQ-009 Accepted write timing: LCD_EN rises at T0+TAS_CYC, falls at T0+TAS_CYC+EN_CYC; EXEC then lasts CLEAR_CYC if address=0 and data ∈ {0x01,0x02}, else EXEC_CYC.
REQ-010 DONE lasts exactly one cycle: waitrequest=0, response=00; the state returns to IDLE next cycle.
REQ-011 waitrequest SHALL be 1 in every state other than DONE.
REQ-012 The slave SHALL latch request fields at acceptance; later changes of chipselect/write/writedata SHALL NOT affect the cycle in flight.
REQ-013 IDLE with chipselect&read&~write: go to DONE next cycle; readdata holds the last accepted byte for that address (0x00 if none); response=00; no LCD cycle.
REQ-014 IDLE with chipselect&write&read, or chipselect&write&~byteenable: go to DONE next cycle with response=10 and no LCD cycle; the last-written registers SHALL be unchanged.
REQ-015 LCD_DATA/LCD_RS SHALL change only in IDLE at acceptance, never while LCD_EN=1 or during HOLD.
REQ-016 readdata SHALL be 0x00 outside DONE.
REQ-017 A request present in DONE SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-018 reset_n=0 SHALL immediately force: LCD_EN=0, LCD_RS=0, LCD_DATA=0x00, LCD_RW=0, waitrequest=1, response=00, readdata=0x00, counter=0, last-written registers=0x00.
REQ-019 Reset mid-transaction SHALL abort the transaction without completing it; after release the FSM enters INIT (LCD_INIT_EN defined) or IDLE (not defined).

Configuration
REQ-020 Macro LCD_INIT_EN defined: after reset the FSM SHALL stay in INIT for 750000 cycles, then issue 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 (RS=0), each with REQ-009 timing, before entering IDLE; Avalon requests are held off with waitrequest=1 and no DONE cycles.
REQ-021 Macro LCD_INIT_EN not defined: INIT SHALL be omitted and IDLE entered the first cycle after reset release.

Verification
REQ-022 Write address=1, data=0x41: LCD_RS=1, LCD_DATA=0x41; LCD_EN high T0+3..T0+18; waitrequest low for one cycle after 2500 EXEC cycles; response=00.
REQ-023 Write address=0, data=0x01: EXEC lasts 82000 cycles before the single DONE cycle.
REQ-024 Write 0x41 to address 1, then read address 1: readdata=0x41, waitrequest low for one cycle, no LCD_EN activity.
REQ-025 Write with byteenable=0, and write with read=1: response=10 on the DONE cycle; LCD_EN stays 0.
REQ-026 Assert reset_n=0 while LCD_EN=1: LCD_EN=0 and waitrequest=1 in the same cycle; a subsequent write completes normally.
REQ-027 With LCD_INIT_EN defined: six LCD_EN pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x06, 0x01 after 750000 cycles; a write requested during init is not completed until init ends.

Source files
------------

// File: rtl/lcd_avalon_slave.sv
// Avalon-MM slave that turns single-byte writes into HD44780 bus cycles (setup, enable pulse, hold, execution wait).
// Optional power-on init sequence is compiled in with `define LCD_INIT_EN.
module lcd_avalon_slave #(
  parameter int TAS_CYC   = 3,
  parameter int EN_CYC    = 16,
  parameter int TH_CYC    = 2,
  parameter int EXEC_CYC  = 2500,
  parameter int CLEAR_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       address,
  input  logic       chipselect,
  input  logic       byteenable,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic [1:0] response,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  localparam int CW = 20;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Every timed state loads (length - 1) and leaves when the counter reaches zero.
  localparam logic [CW-1:0] TAS_LOAD   = CW'(TAS_CYC - 1);
  localparam logic [CW-1:0] EN_LOAD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] TH_LOAD    = CW'(TH_CYC - 1);
  localparam logic [CW-1:0] EXEC_LOAD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYC - 1);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    EXEC  = 3'd5,
    DONE  = 3'd6
  } state_t;

`ifdef LCD_INIT_EN
  localparam state_t RESET_STATE = INIT;
  // The first INIT cycle arms the counter, so load two less than the full wait.
  localparam logic [CW-1:0] INIT_LOAD = CW'(750000 - 2);

  logic       init_mode;
  logic       init_armed;
  logic [2:0] init_idx;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h38;
      3'd3:             init_byte = 8'h0C;
      3'd4:             init_byte = 8'h06;
      default:          init_byte = 8'h01;
    endcase
  endfunction
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    last_instr;
  logic [7:0]    last_data;

  logic          req_write;
  logic          req_read;
  logic          req_bad;
  logic          is_clear;
  logic [CW-1:0] exec_load;

  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

  assign req_write = chipselect & write & ~read & byteenable;
  assign req_read  = chipselect & read & ~write;
  assign req_bad   = chipselect & write & (read | ~byteenable);

  // Clear display and return home need the long execution wait.
  assign is_clear  = ~LCD_RS & ((LCD_DATA == 8'h01) | (LCD_DATA == 8'h02));
  assign exec_load = is_clear ? CLEAR_LOAD : EXEC_LOAD;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RESET_STATE;
      cnt         <= '0;
      LCD_EN      <= 1'b0;
      LCD_RS      <= 1'b0;
      LCD_DATA    <= 8'h00;
      waitrequest <= 1'b1;
      response    <= RESP_OKAY;
      readdata    <= 8'h00;
      last_instr  <= 8'h00;
      last_data   <= 8'h00;
`ifdef LCD_INIT_EN
      init_mode   <= 1'b0;
      init_armed  <= 1'b0;
      init_idx    <= 3'd0;
`endif
    end else begin
      case (state)
        INIT: begin
`ifdef LCD_INIT_EN
          if (!init_armed) begin
            cnt        <= INIT_LOAD;
            init_armed <= 1'b1;
          end else if (cnt == '0) begin
            LCD_RS    <= 1'b0;
            LCD_DATA  <= init_byte(3'd0);
            init_idx  <= 3'd0;
            init_mode <= 1'b1;
            cnt       <= TAS_LOAD;
            state     <= SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
`else
          state <= IDLE;
`endif
        end

        IDLE: begin
          if (req_write) begin
            LCD_RS   <= address;
            LCD_DATA <= writedata;
            if (address) last_data  <= writedata;
            else         last_instr <= writedata;
            cnt      <= TAS_LOAD;
            state    <= SETUP;
          end else if (req_read) begin
            readdata    <= address ? last_data : last_instr;
            response    <= RESP_OKAY;
            waitrequest <= 1'b0;
            state       <= DONE;
          end else if (req_bad) begin
            response    <= RESP_SLVERR;
            waitrequest <= 1'b0;
            state       <= DONE;
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b1;
            cnt    <= EN_LOAD;
            state  <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        PULSE: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b0;
            cnt    <= TH_LOAD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            cnt   <= exec_load;
            state <= EXEC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        EXEC: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_EN
            if (init_mode) begin
              // Init commands chain straight into the next one; no Avalon completion.
              if (init_idx == 3'd5) begin
                init_mode <= 1'b0;
                state     <= IDLE;
              end else begin
                init_idx <= init_idx + 3'd1;
                LCD_DATA <= init_byte(init_idx + 3'd1);
                cnt      <= TAS_LOAD;
                state    <= SETUP;
              end
            end else begin
              response    <= RESP_OKAY;
              waitrequest <= 1'b0;
              state       <= DONE;
            end
`else
            response    <= RESP_OKAY;
            waitrequest <= 1'b0;
            state       <= DONE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          // Any request still present here is ignored until the next IDLE cycle.
          waitrequest <= 1'b1;
          response    <= RESP_OKAY;
          readdata    <= 8'h00;
          state       <= IDLE;
        end

        default: begin
          waitrequest <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_avalon_slave.sv
// Directed, table-driven bench for lcd_avalon_slave in its default build (no power-on init).
module tb_lcd_avalon_slave;

  localparam int TAS_CYC   = 3;
  localparam int EN_CYC    = 16;
  localparam int TH_CYC    = 2;
  localparam int EXEC_CYC  = 2500;
  localparam int CLEAR_CYC = 82000;
  // Samples counted on the falling edges after the accepting rising edge.
  localparam int LAT_W     = TAS_CYC + EN_CYC + TH_CYC + EXEC_CYC + 1;
  localparam int LAT_CLR   = TAS_CYC + EN_CYC + TH_CYC + CLEAR_CYC + 1;
  localparam int LAT_RD    = 1;
  localparam int MAX_K     = 90000;

  logic       clk;
  logic       reset_n;
  logic       address;
  logic       chipselect;
  logic       byteenable;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;
  logic [1:0] response;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_ON;
  logic       LCD_BLON;

  int n_checks = 0;
  int n_errors = 0;

  lcd_avalon_slave dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .byteenable (byteenable),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .waitrequest(waitrequest),
    .response   (response),
    .LCD_DATA   (LCD_DATA),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_EN     (LCD_EN),
    .LCD_ON     (LCD_ON),
    .LCD_BLON   (LCD_BLON)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       addr;
    logic       rd;
    logic       wr;
    logic       be;
    logic [7:0] wdata;
    logic [1:0] resp;
    logic [7:0] rdata;
    int         pulses;
    int         latency;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 1'b0;
    address    = 1'b0;
    writedata  = 8'h00;
  endtask

  // Driver + monitor for one transaction; the request is held until waitrequest drops.
  task automatic run_txn(input vec_t v, input int idx);
    int         k;
    int         done_k;
    int         pulses;
    int         rise_k;
    int         last_hi;
    logic       prev_en;
    logic       stable_bad;
    logic       rd_bad;
    logic [7:0] ref_data;
    logic       ref_rs;
    logic [1:0] got_resp;
    logic [7:0] got_rdata;
    string      tag;
    tag = $sformatf("vec%0d", idx);
    k = 0; done_k = -1; pulses = 0; rise_k = -1; last_hi = -1;
    prev_en = 1'b0; stable_bad = 1'b0; rd_bad = 1'b0;
    ref_data = 8'h00; ref_rs = 1'b0; got_resp = 2'b11; got_rdata = 8'hxx;
    @(negedge clk);
    chipselect = 1'b1;
    address    = v.addr;
    read       = v.rd;
    write      = v.wr;
    byteenable = v.be;
    writedata  = v.wdata;
    while (done_k < 0 && k < MAX_K) begin
      @(negedge clk);
      k++;
      // Changing writedata after acceptance must not reach the LCD bus.
      if (k == 2 && v.wr) writedata = ~v.wdata;
      if (LCD_EN && !prev_en) begin
        pulses++;
        rise_k   = k;
        ref_data = LCD_DATA;
        ref_rs   = LCD_RS;
      end
      if (LCD_EN) last_hi = k;
      if (rise_k > 0 && (LCD_DATA !== ref_data || LCD_RS !== ref_rs)) stable_bad = 1'b1;
      if (waitrequest === 1'b0) begin
        done_k    = k;
        got_resp  = response;
        got_rdata = readdata;
      end else if (readdata !== 8'h00) begin
        rd_bad = 1'b1;
      end
      prev_en = LCD_EN;
    end
    idle_bus();
    if (done_k < 0) $display("FAIL %s_timeout: got no completion in %0d cycles, want one", tag, MAX_K);
    check({tag, "_latency"}, done_k, v.latency);
    check({tag, "_response"}, got_resp, v.resp);
    check({tag, "_readdata"}, got_rdata, v.rdata);
    check({tag, "_en_pulses"}, pulses, v.pulses);
    check({tag, "_readdata_idle"}, rd_bad, 0);
    if (v.pulses > 0) begin
      check({tag, "_en_rise"}, rise_k, TAS_CYC + 1);
      check({tag, "_en_width"}, last_hi - rise_k + 1, EN_CYC);
      check({tag, "_lcd_data"}, ref_data, v.wdata);
      check({tag, "_lcd_rs"}, ref_rs, v.addr);
      check({tag, "_bus_stable"}, stable_bad, 0);
    end
    @(negedge clk);
    check({tag, "_wait_after_done"}, waitrequest, 1);
    check({tag, "_lcd_rw"}, LCD_RW, 0);
  endtask

  initial begin
    int k;
    int seen_en;

    //             addr  rd    wr    be    wdata  resp   rdata  pls latency
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 2'b00, 8'h00, 1, LAT_W};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 8'h41, 0, LAT_RD};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00, 0, LAT_RD};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 2'b10, 8'h00, 0, LAT_RD};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 2'b10, 8'h00, 0, LAT_RD};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 8'h41, 0, LAT_RD};
    // After a reset the stored bytes are gone, then the long clear-display wait.
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 8'h00, 0, LAT_RD};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 2'b00, 8'h00, 1, LAT_CLR};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2'b00, 8'h01, 0, LAT_RD};

    idle_bus();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lcd_en", LCD_EN, 0);
    check("rst_lcd_rs", LCD_RS, 0);
    check("rst_lcd_data", LCD_DATA, 8'h00);
    check("rst_lcd_rw", LCD_RW, 0);
    check("rst_waitrequest", waitrequest, 1);
    check("rst_response", response, 2'b00);
    check("rst_readdata", readdata, 8'h00);
    check("rst_lcd_on", {LCD_ON, LCD_BLON}, 2'b11);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_waitrequest", waitrequest, 1);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // A read held through DONE is taken again only after one IDLE cycle.
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 1'b1; byteenable = 1'b1;
    @(negedge clk);
    check("held_rd_done1", {waitrequest, readdata}, {1'b0, 8'h41});
    @(negedge clk);
    check("held_rd_idle", {waitrequest, readdata}, {1'b1, 8'h00});
    @(negedge clk);
    check("held_rd_done2", {waitrequest, readdata}, {1'b0, 8'h41});
    idle_bus();
    @(negedge clk);
    check("held_rd_release", waitrequest, 1);

    // Reset arriving while the enable strobe is high aborts the write at once.
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 1'b1; byteenable = 1'b1; writedata = 8'h5A;
    seen_en = 0;
    for (k = 0; k < 40 && seen_en == 0; k++) begin
      @(negedge clk);
      if (LCD_EN === 1'b1) seen_en = 1;
    end
    check("abort_en_seen", seen_en, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_en_low", LCD_EN, 0);
    check("abort_waitrequest", waitrequest, 1);
    check("abort_lcd_bus", {LCD_RS, LCD_DATA}, 9'h000);
    idle_bus();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_completion", {LCD_EN, waitrequest}, 2'b01);

    for (int i = 6; i < 9; i++) run_txn(vecs[i], i);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
